gate_bist: RTL and testbench
============================

Name: gate_bist

Overview:
- Synchronous built-in self-test controller for the basic-gate library.
- Drives an exhaustive input sequence into a gate under test and samples the gate's output after a settle delay.
- Compares each sample against a parameterised truth table, then reports pass/fail with first-failure capture.
- This block is the checking end of the gate interface: stimulus out, response in. It is instantiated beside any BASIC_GATES cell for silicon/FPGA self-check.

Parameters:
- N_INPUTS, 2, number of gate inputs; the sequence covers 2**N_INPUTS vectors.
- SETTLE_CYCLES, 2, clock cycles between applying a vector and sampling dut_out; legal range 1..15.
- TRUTH, 4'b1000, expected output table (width 2**N_INPUTS); the expected value for vector v is TRUTH[v]. Default is AND.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a test run; sampled only in IDLE or DONE.
- dut_in  output  N_INPUTS  vector to gate under test; bit0 = a, bit1 = b.
- dut_out  input  1  gate under test output.
- busy  output  1  run in progress.
- done  output  1  run complete; held until next start.
- pass  output  1  done and zero mismatches.
- fail_cnt  output  N_INPUTS+1  number of mismatching vectors; saturates at all-ones.
- fail_vec  output  N_INPUTS  first mismatching vector; 0 if none.

Behaviour:
- Reset (async assert, sync release): state = IDLE; dut_in = 0, busy = 0, done = 0, pass = 0, fail_cnt = 0, fail_vec = 0, settle counter = 0. Reset mid-run aborts immediately with no partial result.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE → SETTLE on start = 1:
  - dut_in <= 0, cnt <= 0, busy <= 1.
  - fail_cnt, fail_vec and the first-fail flag are cleared.
- SETTLE: cnt increments each cycle. When cnt == SETTLE_CYCLES-1, next state is SAMPLE.
- SAMPLE (one cycle): compare dut_out with TRUTH[dut_in].
  - On mismatch: fail_cnt++ (saturating). If this is the first failure of the run, fail_vec <= dut_in.
  - If dut_in == 2**N_INPUTS-1: next state DONE, busy <= 0, done <= 1, pass <= (no mismatch this run including this sample).
  - Otherwise: dut_in <= dut_in+1, cnt <= 0, next state SETTLE.
- DONE:
  - Outputs are held.
  - dut_in holds the last vector.
  - start = 1 behaves exactly as start in IDLE (restart); done and pass drop the cycle after.
- Start while busy is ignored.
- Latency: each vector takes SETTLE_CYCLES+1 cycles. done rises (SETTLE_CYCLES+1)*2**N_INPUTS clock edges after the edge that samples start; the default is 12.
- dut_in changes only on SAMPLE→SETTLE transitions. It is stable for every sampled cycle, and the gate sees each vector for SETTLE_CYCLES+1 cycles.
- dut_out is treated as synchronous to clk; no synchroniser is included.
- X on dut_out counts as a mismatch (compare with !==-style semantics in simulation).

Decomposition:
- gate_bist_pkg:
  - state enum {IDLE, SETTLE, SAMPLE, DONE}.
  - Truth constants: TRUTH_AND = 4'b1000, TRUTH_OR = 4'b1110, TRUTH_XOR = 4'b0110, TRUTH_NAND = 4'b0111, TRUTH_NOR = 4'b0001.
- Sub-module gate_bist_seq: vector counter plus settle timer, with outputs vec, sample_strobe and last.
- gate_bist top: FSM, compare logic and result registers.

Test Plan:
- Reset with and_gate attached, TRUTH_AND, pulse start → busy for 12 cycles; dut_in steps 0,1,2,3 at 3-cycle spacing; done = 1, pass = 1, fail_cnt = 0.
- Same, but gate replaced by an OR model → mismatches at vectors 1 and 2; fail_cnt = 2, fail_vec = 1, pass = 0.
- dut_out stuck at 1 with TRUTH_AND → fail_cnt = 3, fail_vec = 0. Then restart from DONE with a correct gate → fail_cnt = 0, pass = 1.
- Assert rst_n low at cycle 5 of a run → all outputs 0 asynchronously. After release with no start, the block stays IDLE and dut_in = 0.
- Pulse start again during a run at cycle 4 → ignored; done still at cycle 12 relative to the first start.
- SETTLE_CYCLES = 1 and N_INPUTS = 2 with TRUTH_XOR and an xor gate → done after 8 cycles, pass = 1.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate BIST controller.
// Truth tables are indexed by the input vector {b, a}, so TRUTH[v] is the expected output.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int SETTLE_W = 4;

  localparam logic [3:0] TRUTH_AND  = 4'b1000;
  localparam logic [3:0] TRUTH_OR   = 4'b1110;
  localparam logic [3:0] TRUTH_XOR  = 4'b0110;
  localparam logic [3:0] TRUTH_NAND = 4'b0111;
  localparam logic [3:0] TRUTH_NOR  = 4'b0001;

endpackage

// File: rtl/gate_bist_seq.sv
// Vector counter and settle timer for the gate BIST controller.
// The timer counts only while run is high; step moves on to the next vector and rearms the timer.
module gate_bist_seq
  import gate_bist_pkg::*;
#(
  parameter int N_INPUTS      = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                run,
  input  logic                step,
  output logic [N_INPUTS-1:0] vec,
  output logic                sample_strobe,
  output logic                last
);

  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec <= '0;
      cnt <= '0;
    end else if (clear) begin
      vec <= '0;
      cnt <= '0;
    end else if (step) begin
      vec <= vec + 1'b1;
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sample_strobe = run && (cnt == SETTLE_W'(SETTLE_CYCLES - 1));
  assign last          = &vec;

endmodule

// File: rtl/gate_bist.sv
// Self-test controller for a basic gate: walks all input vectors, samples the gate after a
// settle delay, and reports mismatch count, first failing vector and an overall pass flag.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int                         N_INPUTS      = 2,
  parameter int                         SETTLE_CYCLES = 2,
  parameter logic [2**N_INPUTS-1:0]     TRUTH         = TRUTH_AND
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [N_INPUTS-1:0] dut_in,
  input  logic                dut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   fail_cnt,
  output logic [N_INPUTS-1:0] fail_vec
);

  state_t              state;
  logic                clear;
  logic                run;
  logic                step;
  logic                sample_strobe;
  logic                last;
  logic                mismatch;
  logic [N_INPUTS-1:0] vec;

  assign clear = start && ((state == IDLE) || (state == DONE));
  assign run   = (state == SETTLE);
  assign step  = (state == SAMPLE) && !last;

  gate_bist_seq #(
    .N_INPUTS      (N_INPUTS),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_seq (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .run           (run),
    .step          (step),
    .vec           (vec),
    .sample_strobe (sample_strobe),
    .last          (last)
  );

  assign dut_in = vec;

  // Case inequality so an unknown gate output is reported as a failure in simulation.
  assign mismatch = (dut_out !== TRUTH[vec]);

  // A nonzero fail count doubles as the first-failure flag: it never returns to zero mid-run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_cnt <= '0;
      fail_vec <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= SETTLE;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_cnt <= '0;
            fail_vec <= '0;
          end
        end
        SETTLE: begin
          if (sample_strobe) state <= SAMPLE;
        end
        SAMPLE: begin
          if (mismatch) begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            if (fail_cnt == '0) fail_vec <= vec;
          end
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_cnt == '0) && !mismatch;
          end else begin
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist.sv
// Self-checking bench for gate_bist: two instances (default timing/AND, and 1-cycle settle/XOR)
// driven by table-modelled gates, checked against a vector-by-vector reference of the test run.
module tb_gate_bist;
  import gate_bist_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start0 = 1'b0, start1 = 1'b0;
  logic [1:0] dut_in0, dut_in1;
  logic       dut_out0, dut_out1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [2:0] fail_cnt0, fail_cnt1;
  logic [1:0] fail_vec0, fail_vec1;

  logic [3:0] gate0 = TRUTH_AND;
  logic [3:0] gate1 = TRUTH_XOR;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign dut_out0 = gate0[dut_in0];
  assign dut_out1 = gate1[dut_in1];

  gate_bist dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start0),
    .dut_in   (dut_in0),
    .dut_out  (dut_out0),
    .busy     (busy0),
    .done     (done0),
    .pass     (pass0),
    .fail_cnt (fail_cnt0),
    .fail_vec (fail_vec0)
  );

  gate_bist #(
    .N_INPUTS      (2),
    .SETTLE_CYCLES (1),
    .TRUTH         (TRUTH_XOR)
  ) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start1),
    .dut_in   (dut_in1),
    .dut_out  (dut_out1),
    .busy     (busy1),
    .done     (done1),
    .pass     (pass1),
    .fail_cnt (fail_cnt1),
    .fail_vec (fail_vec1)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference: walk every vector, compare gate response with the truth table.
  function automatic void refModel(input logic [3:0] truth, input logic [3:0] gate,
                                   output int cnt, output int fvec);
    cnt  = 0;
    fvec = 0;
    for (int v = 0; v < 4; v++) begin
      if (gate[v] != truth[v]) begin
        if (cnt == 0) fvec = v;
        if (cnt < 7) cnt++;
      end
    end
  endfunction

  function automatic int obsIn(input int which);
    return (which == 0) ? int'(dut_in0) : int'(dut_in1);
  endfunction
  function automatic int obsBusy(input int which);
    return (which == 0) ? int'(busy0) : int'(busy1);
  endfunction
  function automatic int obsDone(input int which);
    return (which == 0) ? int'(done0) : int'(done1);
  endfunction
  function automatic int obsPass(input int which);
    return (which == 0) ? int'(pass0) : int'(pass1);
  endfunction
  function automatic int obsCnt(input int which);
    return (which == 0) ? int'(fail_cnt0) : int'(fail_cnt1);
  endfunction
  function automatic int obsVec(input int which);
    return (which == 0) ? int'(fail_vec0) : int'(fail_vec1);
  endfunction

  task automatic setStart(input int which, input logic v);
    if (which == 0) start0 = v;
    else start1 = v;
  endtask

  // Runs one full test on the chosen instance; glitch_at > 0 re-pulses start during the run.
  task automatic applyStimulus(input int which, input logic [3:0] gate, input int glitch_at);
    int sc, total, exp_cnt, exp_vec, first_done, exp_in;
    logic [3:0] truth;
    sc    = (which == 0) ? 2 : 1;
    truth = (which == 0) ? TRUTH_AND : TRUTH_XOR;
    total = (sc + 1) * 4;
    refModel(truth, gate, exp_cnt, exp_vec);
    if (which == 0) gate0 = gate;
    else gate1 = gate;

    setStart(which, 1'b1);
    @(posedge clk);
    #1;
    setStart(which, 1'b0);
    checkOutput("start_busy", obsBusy(which), 1);
    checkOutput("start_done_clr", obsDone(which), 0);
    checkOutput("start_pass_clr", obsPass(which), 0);
    checkOutput("start_cnt_clr", obsCnt(which), 0);
    checkOutput("start_in_zero", obsIn(which), 0);

    first_done = -1;
    for (int k = 1; k <= total + 2; k++) begin
      if (k == glitch_at) setStart(which, 1'b1);
      @(posedge clk);
      #1;
      setStart(which, 1'b0);
      exp_in = (k < total) ? k / (sc + 1) : 3;
      checkOutput("step_dut_in", obsIn(which), exp_in);
      checkOutput("step_busy", obsBusy(which), (k < total) ? 1 : 0);
      checkOutput("step_done", obsDone(which), (k >= total) ? 1 : 0);
      if (first_done < 0 && obsDone(which) == 1) first_done = k;
    end
    checkOutput("done_latency", first_done, total);
    checkOutput("fail_cnt", obsCnt(which), exp_cnt);
    checkOutput("fail_vec", obsVec(which), exp_vec);
    checkOutput("pass", obsPass(which), (exp_cnt == 0) ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #3;
    checkOutput("rst_busy", busy0, 0);
    checkOutput("rst_done", done0, 0);
    checkOutput("rst_pass", pass0, 0);
    checkOutput("rst_fail_cnt", fail_cnt0, 0);
    checkOutput("rst_fail_vec", fail_vec0, 0);
    checkOutput("rst_dut_in", dut_in0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(0, TRUTH_AND, 0);
    applyStimulus(0, TRUTH_OR, 0);
    applyStimulus(0, 4'b1111, 0);
    applyStimulus(0, TRUTH_AND, 0);
    applyStimulus(0, TRUTH_AND, 4);
    applyStimulus(0, TRUTH_NOR, 7);

    // Reset in the middle of a run with a failure already recorded.
    gate0 = 4'b1111;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("mid_busy", busy0, 1);
    checkOutput("mid_fail_cnt", fail_cnt0, 1);
    checkOutput("mid_dut_in", dut_in0, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", busy0, 0);
    checkOutput("arst_done", done0, 0);
    checkOutput("arst_pass", pass0, 0);
    checkOutput("arst_fail_cnt", fail_cnt0, 0);
    checkOutput("arst_fail_vec", fail_vec0, 0);
    checkOutput("arst_dut_in", dut_in0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("idle_busy", busy0, 0);
    checkOutput("idle_done", done0, 0);
    checkOutput("idle_dut_in", dut_in0, 0);

    applyStimulus(1, TRUTH_XOR, 0);
    applyStimulus(1, TRUTH_NAND, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 4'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11)) : 0);
      applyStimulus(1, 4'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
